// File: rtl/seg7_scan_decoder.sv
// Samples a multiplexed 7-segment bus, filters scan glitches and decodes each glyph
// back to a hex nibble held per digit, with sticky valid/error flags and frame pulses.
module seg7_scan_decoder #(
   parameter int NDIG       = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [6:0]          seg_in,
   input  logic [NDIG-1:0]     dig_in,
   input  logic                clr,
   output logic [4*NDIG-1:0]   hex_out,
   output logic [NDIG-1:0]     dig_valid,
   output logic                frame_done,
   output logic                glyph_err
);

   localparam int CW = $clog2(STABLE_CYC + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRACK,
      ST_HOLD
   } state_t;

   logic [6:0]        seg_s1_q, seg_s2_q;
   logic [NDIG-1:0]   dig_s1_q, dig_s2_q;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [6:0]        seg_lat_q, seg_lat_d;
   logic [NDIG-1:0]   dig_lat_q, dig_lat_d;
   logic [4*NDIG-1:0] hex_q, hex_d;
   logic [NDIG-1:0]   valid_q, valid_d;
   logic [NDIG-1:0]   mask_q, mask_d;
   logic              frame_done_q, frame_done_d;
   logic              err_q, err_d;

   logic              dig_multi;
   logic              blank;
   logic              pair_same;
   logic              capture;
   logic [4:0]        glyph;

   // Returns {valid, nibble}; bit order of seg is {g,f,e,d,c,b,a}.
   function automatic logic [4:0] decode(input logic [6:0] seg);
      logic [4:0] r;
      case (seg)
         7'h3F:   r = 5'h10;
         7'h06:   r = 5'h11;
         7'h5B:   r = 5'h12;
         7'h4F:   r = 5'h13;
         7'h66:   r = 5'h14;
         7'h6D:   r = 5'h15;
         7'h7D:   r = 5'h16;
         7'h07:   r = 5'h17;
         7'h7F:   r = 5'h18;
         7'h6F:   r = 5'h19;
         7'h77:   r = 5'h1A;
         7'h7C:   r = 5'h1B;
         7'h39:   r = 5'h1C;
         7'h5E:   r = 5'h1D;
         7'h79:   r = 5'h1E;
         7'h71:   r = 5'h1F;
         default: r = 5'h00;
      endcase
      return r;
   endfunction

   assign dig_multi = (dig_s2_q & (dig_s2_q - NDIG'(1))) != '0;
   assign blank     = (dig_s2_q == '0) || (seg_s2_q == '0) || dig_multi;
   assign pair_same = (seg_s2_q == seg_lat_q) && (dig_s2_q == dig_lat_q);
   assign glyph     = decode(seg_lat_q);

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      seg_lat_d    = seg_lat_q;
      dig_lat_d    = dig_lat_q;
      hex_d        = hex_q;
      valid_d      = valid_q;
      err_d        = err_q;
      capture      = 1'b0;
      frame_done_d = 1'b0;
      mask_d       = mask_q;

      // A completed frame is reported one edge later; a capture on that edge opens the next frame.
      if (mask_q == '1) begin
         frame_done_d = 1'b1;
         mask_d       = '0;
      end

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!blank) begin
               state_d   = ST_TRACK;
               cnt_d     = CW'(1);
               seg_lat_d = seg_s2_q;
               dig_lat_d = dig_s2_q;
            end
         end
         ST_TRACK: begin
            if (blank) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (!pair_same) begin
               cnt_d     = CW'(1);
               seg_lat_d = seg_s2_q;
               dig_lat_d = dig_s2_q;
            end else if (cnt_q >= CW'(STABLE_CYC - 1)) begin
               state_d = ST_HOLD;
               cnt_d   = CW'(STABLE_CYC);
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         ST_HOLD: begin
            if (blank) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end else if (!pair_same) begin
               state_d   = ST_TRACK;
               cnt_d     = CW'(1);
               seg_lat_d = seg_s2_q;
               dig_lat_d = dig_s2_q;
            end
         end
         default: begin
            state_d = ST_IDLE;
            cnt_d   = '0;
         end
      endcase

      if (dig_multi) err_d = 1'b1;

      if (capture) begin
         if (glyph[4]) begin
            for (int unsigned k = 0; k < NDIG; k++) begin
               if (dig_lat_q[k]) begin
                  hex_d[4*k +: 4] = glyph[3:0];
                  valid_d[k]      = 1'b1;
                  mask_d[k]       = 1'b1;
               end
            end
         end else begin
            err_d = 1'b1;
         end
      end

      if (clr) begin
         state_d      = ST_IDLE;
         cnt_d        = '0;
         hex_d        = '0;
         valid_d      = '0;
         mask_d       = '0;
         err_d        = 1'b0;
         frame_done_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_s1_q     <= '0;
         seg_s2_q     <= '0;
         dig_s1_q     <= '0;
         dig_s2_q     <= '0;
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         seg_lat_q    <= '0;
         dig_lat_q    <= '0;
         hex_q        <= '0;
         valid_q      <= '0;
         mask_q       <= '0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         seg_s1_q     <= seg_in;
         seg_s2_q     <= seg_s1_q;
         dig_s1_q     <= dig_in;
         dig_s2_q     <= dig_s1_q;
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         seg_lat_q    <= seg_lat_d;
         dig_lat_q    <= dig_lat_d;
         hex_q        <= hex_d;
         valid_q      <= valid_d;
         mask_q       <= mask_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
      end
   end

   assign hex_out    = hex_q;
   assign dig_valid  = valid_q;
   assign frame_done = frame_done_q;
   assign glyph_err  = err_q;

endmodule
